conv_block_sequencer: RTL and testbench

Frame-level controller for the 2D-convolution address FSM, which has load, SoP, valid, changeBlock and EoP handshakes. A frame is split into N column blocks. For each block the sequencer runs three phases in order: LOAD, PROC, READ. It drives the FSM's i_load/i_SoP/i_valid and counts blocks, so the host issues one start per frame instead of hand-toggling the FSM.

---
 rtl/conv_seq_pkg.sv | 29 ++
 rtl/seq_watchdog.sv | 28 ++
 rtl/conv_block_sequencer.sv | 145 ++++++++++++++
 tb/tb_conv_block_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - state encodings, phase codes and constants for the convolution block sequencer
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAP  = 3'd1,
        LOAD = 3'd2,
        PROC = 3'd3,
        READ = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_LOAD = 2'd1;
    localparam logic [1:0] PH_PROC = 2'd2;
    localparam logic [1:0] PH_READ = 2'd3;

    localparam int WDOG_MARGIN = 8;

    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            LOAD:    phase_of = PH_LOAD;
            PROC:    phase_of = PH_PROC;
            READ:    phase_of = PH_READ;
            default: phase_of = PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - saturating cycle counter with limit latch and expire pulse
module seq_watchdog #(
    parameter int NB = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [NB-1:0] limit,
    output logic          expire
);

    logic [NB-1:0] count;
    logic [NB-1:0] lim_q;

    // The limit is captured while held clear so it is stable for the whole run.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
            lim_q <= limit;
        end else if (en && (count != '1)) begin
            count <= count + NB'(1);
        end
    end

    assign expire = en && !clr && (count == lim_q);

endmodule

// File: rtl/conv_block_sequencer.sv
// rtl/conv_block_sequencer.sv - per-frame LOAD/PROC/READ sequencer for the 2D-convolution address FSM (SEQ_AUTOVALID_EN: internal valid square wave)
module conv_block_sequencer
    import conv_seq_pkg::*;
#(
    parameter int NB_IMAGE   = 10,
    parameter int NB_BLOCK   = 8,
    parameter int NB_WDOG    = 16,
    parameter int LATENCIA   = 6,
    parameter int GAP_CYCLES = 2
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_IMAGE-1:0] i_imgLength,
    input  logic [NB_BLOCK-1:0] i_nBlocks,
    input  logic                i_hostValid,
    input  logic                i_changeBlock,
    input  logic                i_EoP,
    output logic                o_load,
    output logic                o_SoP,
    output logic                o_valid,
    output logic [NB_BLOCK-1:0] o_blockIdx,
    output logic [1:0]          o_phase,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t              state;
    state_t              pending;
    logic [NB_IMAGE-1:0] len_q;
    logic [NB_BLOCK-1:0] nblk_q;
    logic [GW-1:0]       gap_cnt;
    logic                cb_q;
    logic                cb_rise;
    logic                wd_expire;
    logic                fwd_state;
    logic                valid_next;
    logic [NB_WDOG-1:0]  wd_limit;

    assign cb_rise   = i_changeBlock & ~cb_q;
    assign fwd_state = (state == LOAD) || (state == READ);
    assign wd_limit  = NB_WDOG'(len_q) + NB_WDOG'(LATENCIA + WDOG_MARGIN);

    seq_watchdog #(.NB(NB_WDOG)) u_wdog (
        .clk    (i_CLK),
        .reset  (i_reset),
        .clr    (state != PROC),
        .en     (state == PROC),
        .limit  (wd_limit),
        .expire (wd_expire)
    );

`ifdef SEQ_AUTOVALID_EN
    logic tog;
    logic unused_host;
    assign unused_host = i_hostValid;

    // Re-armed high outside the forwarding phases so every phase opens with a 1.
    always_ff @(posedge i_CLK) begin
        if (i_reset || !fwd_state) tog <= 1'b1;
        else                       tog <= ~tog;
    end
    assign valid_next = fwd_state & tog;
`else
    assign valid_next = fwd_state & i_hostValid;
`endif

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state      <= IDLE;
            pending    <= IDLE;
            len_q      <= '0;
            nblk_q     <= '0;
            gap_cnt    <= '0;
            cb_q       <= 1'b0;
            o_load     <= 1'b0;
            o_SoP      <= 1'b0;
            o_valid    <= 1'b0;
            o_blockIdx <= '0;
            o_phase    <= PH_IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            cb_q    <= i_changeBlock;
            o_done  <= 1'b0;
            o_phase <= phase_of(state);
            o_load  <= (state == LOAD) && !cb_rise;
            o_SoP   <= (state == PROC) && !cb_rise && !wd_expire;
            o_valid <= valid_next;
            case (state)
                IDLE: if (i_start) begin
                    len_q      <= i_imgLength;
                    nblk_q     <= i_nBlocks;
                    o_error    <= 1'b0;
                    o_busy     <= 1'b1;
                    o_blockIdx <= '0;
                    gap_cnt    <= '0;
                    pending    <= LOAD;
                    state      <= (i_nBlocks == '0) ? DONE : GAP;
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= pending;
                    else                                gap_cnt <= gap_cnt + GW'(1);
                end
                LOAD: if (cb_rise) begin
                    gap_cnt <= '0;
                    pending <= PROC;
                    state   <= GAP;
                end
                PROC: begin
                    if (cb_rise) begin
                        gap_cnt <= '0;
                        pending <= READ;
                        state   <= GAP;
                    end else if (wd_expire) begin
                        o_error <= 1'b1;
                        state   <= DONE;
                    end
                end
                // A change-block with EoP high is an intermediate read pass, not block end.
                READ: if (cb_rise && !i_EoP) begin
                    if (o_blockIdx == nblk_q - NB_BLOCK'(1)) begin
                        state <= DONE;
                    end else begin
                        o_blockIdx <= o_blockIdx + NB_BLOCK'(1);
                        gap_cnt    <= '0;
                        pending    <= LOAD;
                        state      <= GAP;
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_block_sequencer.sv
// tb/tb_conv_block_sequencer.sv - self-checking bench for conv_block_sequencer
module tb_conv_block_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, host, cb, eop;
    logic [9:0] img;
    logic [7:0] nbl;
    logic       load, sop, valid, busy, done, err;
    logic [7:0] idx;
    logic [1:0] phase;

    int tests = 0;
    int fails = 0;
    int runs[$];
    int gaps[$];
    int idxs[$];
    int vbad, done_cnt, sop_cnt, sop_at_err, lsop_cnt;
    bit busy_at_done, sop_low_at_err;

    always #5 clk = ~clk;

    conv_block_sequencer dut (
        .i_CLK         (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_imgLength   (img),
        .i_nBlocks     (nbl),
        .i_hostValid   (host),
        .i_changeBlock (cb),
        .i_EoP         (eop),
        .o_load        (load),
        .o_SoP         (sop),
        .o_valid       (valid),
        .o_blockIdx    (idx),
        .o_phase       (phase),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len, input int nblk);
        img   = 10'(len);
        nbl   = 8'(nblk);
        start = 1'b1;
        tick();
        start = 1'b0;
        img   = 10'($urandom);
        nbl   = 8'($urandom);
        check("busy_after_start", busy, 1);
    endtask

    // Address-FSM stand-in: answers each phase with changeBlock pulses and records what it sees.
    task automatic run_frame(input int passes, input bit hang, input bit poke, input bit stop_proc);
        int prev = 0, idle = 0, ph_cyc = 0, vcnt = 0, pulses = 0, fire_at = 0, cyc = 0;
        bit fired = 0, prev_host = 0, fin = 0, exp_v;
        runs.delete(); gaps.delete(); idxs.delete();
        vbad = 0; done_cnt = 0; sop_cnt = 0; sop_at_err = -1; lsop_cnt = 0;
        sop_low_at_err = 0; busy_at_done = 1;
        prev = int'(phase);
        while (!fin && cyc < 20000) begin
            cb = 0; eop = 0; start = 0;
            if (!fired) begin
                case (phase)
                    2'd1: if (vcnt >= 11) begin cb = 1; fired = 1; end
                    2'd2: if (!hang && ph_cyc >= fire_at) begin cb = 1; fired = 1; end
                    2'd3: if (ph_cyc == 2 * pulses + 1) begin
                        cb = 1;
                        eop = (pulses < passes);
                        pulses++;
                        fired = (pulses > passes);
                    end
                    default: ;
                endcase
            end
            if (poke && phase == 2'd2 && ph_cyc == 0) begin start = 1; nbl = 8'd5; img = 10'd1; end
`ifdef SEQ_AUTOVALID_EN
            host = 1'b0;
`else
            host = 1'($urandom_range(0, 1));
`endif
            prev_host = host;
            tick();
            cyc++;
            if (phase == 2'd0) idle++;
            else if (int'(phase) != prev) begin
                if (runs.size() > 0) gaps.push_back(prev == 0 ? idle : 0);
                runs.push_back(int'(phase));
                idxs.push_back(int'(idx));
                idle = 0; ph_cyc = 0; vcnt = 0; pulses = 0; fired = 0;
                fire_at = $urandom_range(0, 12);
            end else ph_cyc++;
`ifdef SEQ_AUTOVALID_EN
            exp_v = (phase == 2'd1 || phase == 2'd3) && (ph_cyc % 2 == 0);
`else
            exp_v = (phase == 2'd1 || phase == 2'd3) ? prev_host : 1'b0;
`endif
            if (valid !== exp_v) vbad++;
            if (valid && phase == 2'd1) vcnt++;
            if (sop) sop_cnt++;
            if (load || sop) lsop_cnt++;
            if (err && sop_at_err < 0) begin sop_at_err = sop_cnt; sop_low_at_err = !sop; end
            if (done) begin done_cnt++; busy_at_done = busy; fin = 1; end
            if (stop_proc && phase == 2'd2) fin = 1;
            prev = int'(phase);
        end
        cb = 0; eop = 0; start = 0;
        check("frame_in_budget", fin, 1);
    endtask

    task automatic check_frame(input string tag, input int nblk);
        int bad_ph = 0, bad_idx = 0, bad_gap = 0;
        foreach (runs[i]) begin
            if (runs[i] != i % 3 + 1) bad_ph++;
            if (idxs[i] != i / 3) bad_idx++;
        end
        foreach (gaps[i]) if (gaps[i] != 2) bad_gap++;
        check({tag, "_phase_runs"}, runs.size(), 3 * nblk);
        check({tag, "_phase_order"}, bad_ph, 0);
        check({tag, "_block_idx_seq"}, bad_idx, 0);
        check({tag, "_gap_len"}, bad_gap, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        check({tag, "_error"}, err, 0);
        check({tag, "_valid"}, vbad, 0);
        check({tag, "_last_idx"}, idx, nblk - 1);
    endtask

    initial begin
        int n;
        rst = 1; start = 0; host = 0; cb = 0; eop = 0; img = 0; nbl = 0;
        tick(); tick();
        check("rst_load", load, 0);
        check("rst_sop", sop, 0);
        check("rst_valid", valid, 0);
        check("rst_idx", idx, 0);
        check("rst_phase", phase, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", err, 0);
        rst = 0;
        tick();

        start_frame(10, 1);
        run_frame(0, 0, 0, 0);
        check_frame("single", 1);

        start_frame(10, 3);
        run_frame(2, 0, 0, 0);
        check_frame("three_blocks", 3);

        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 4);
            start_frame($urandom_range(0, 1023), n);
            run_frame($urandom_range(0, 2), 0, 0, 0);
            check_frame("random", n);
        end

        start_frame(10, 1);
        run_frame(1, 0, 1, 0);
        check_frame("start_while_busy", 1);

        start_frame(3, 255);
        run_frame(0, 0, 0, 0);
        check_frame("max_blocks", 255);

        start_frame(10, 2);
        run_frame(0, 1, 0, 0);
        check("wdog_phase_runs", runs.size(), 2);
        check("wdog_sop_cycles", sop_at_err, 24);
        check("wdog_sop_dropped", sop_low_at_err, 1);
        check("wdog_done_pulses", done_cnt, 1);
        check("wdog_error", err, 1);
        repeat (3) tick();
        check("wdog_error_sticky", err, 1);

        img = 10'd5; nbl = 8'd0; start = 1;
        tick();
        start = 0;
        check("degen_busy", busy, 1);
        check("degen_done_early", done, 0);
        check("degen_error_cleared", err, 0);
        tick();
        check("degen_done", done, 1);
        check("degen_busy_low", busy, 0);
        check("degen_load_sop", {load, sop}, 0);
        tick();
        check("degen_done_single", done, 0);

        start_frame(10, 1);
        run_frame(0, 0, 0, 1);
        check("reach_proc", phase, 2);
        rst = 1; start = 1; img = 10'd7; nbl = 8'd3;
        tick();
        check("midrst_outputs", {load, sop, valid, idx, phase, busy, done, err}, 0);
        rst = 0; start = 0;
        tick();
        check("midrst_not_started", {busy, phase}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
